// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  localparam int unsigned MEM_BYTES_DFLT = 65536;
  localparam logic [1:0]  ALIGN_MASK     = 2'b11;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter, bundled for port connection.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] adr0, adr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              ack0, ack1;
  logic              err0, err1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic [ADDR_W-1:0] mem_adr;
  logic [DATA_W-1:0] mem_d_in;
  logic              mem_mrd, mem_mwr;
  logic [DATA_W-1:0] mem_d_out;

  // Arbiter side
  modport slave (
    input  req0, req1, we0, we1, adr0, adr1, wdata0, wdata1, mem_d_out,
    output ack0, ack1, err0, err1, rdata0, rdata1,
           mem_adr, mem_d_in, mem_mrd, mem_mwr
  );

  // Requesters and memory model side
  modport master (
    output req0, req1, we0, we1, adr0, adr1, wdata0, wdata1, mem_d_out,
    input  ack0, ack1, err0, err1, rdata0, rdata1,
           mem_adr, mem_d_in, mem_mrd, mem_mwr
  );
endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way winner select; the last-winner register lives in the parent.
module rr_arb2
  import mem_arb_pkg::*;
#(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  output logic win_valid_o,
  output logic win_id_o
);

  // Tie goes to port 0 in fixed mode, otherwise to the port that did not win last.
  always_comb begin
    win_valid_o = req0_i | req1_i;
    win_id_o    = PORT_FETCH;
    if (req0_i && req1_i) begin
      win_id_o = (FIXED_PRIO != 0) ? PORT_FETCH : ~last_i;
    end else if (req1_i) begin
      win_id_o = PORT_DATA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter and access sequencer for the shared 64 KiB memory.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_BYTES  = MEM_BYTES_DFLT,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_arbiter_if.slave   bus,
  output logic           busy
);

  localparam logic [ADDR_W-1:0] ADR_MAX = ADDR_W'(MEM_BYTES - 4);

  state_e            state_q;
  logic              id_q, we_q, last_q, busy_q;
  logic [ADDR_W-1:0] adr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              ack0_q, ack1_q, err0_q, err1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic              mrd_q, mwr_q;

  logic              win_valid, win_id;
  logic              sel_we_d, reject_d;
  logic [ADDR_W-1:0] sel_adr_d;
  logic [DATA_W-1:0] sel_wdata_d;

  rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
    .req0_i      (bus.req0),
    .req1_i      (bus.req1),
    .last_i      (last_q),
    .win_valid_o (win_valid),
    .win_id_o    (win_id)
  );

  // Mux the winning request and decide up front whether it must be rejected.
  always_comb begin
    sel_we_d    = (win_id == PORT_DATA) ? bus.we1    : bus.we0;
    sel_adr_d   = (win_id == PORT_DATA) ? bus.adr1   : bus.adr0;
    sel_wdata_d = (win_id == PORT_DATA) ? bus.wdata1 : bus.wdata0;
    reject_d    = (|(sel_adr_d[1:0] & ALIGN_MASK)) || (sel_adr_d > ADR_MAX);
  end

  // Access sequencer: all outputs registered, strobes only high during SERVE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      id_q     <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      wdata_q  <= '0;
      last_q   <= 1'b1;
      busy_q   <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      mrd_q    <= 1'b0;
      mwr_q    <= 1'b0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      err0_q <= 1'b0;
      err1_q <= 1'b0;
      mrd_q  <= 1'b0;
      mwr_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_valid) begin
            id_q    <= win_id;
            we_q    <= sel_we_d;
            adr_q   <= sel_adr_d;
            wdata_q <= sel_wdata_d;
            last_q  <= win_id;
            busy_q  <= 1'b1;
            if (reject_d) begin
              // Rejected access goes straight to DONE so ack lands one cycle after grant.
              state_q <= DONE;
              if (win_id == PORT_DATA) begin
                ack1_q   <= 1'b1;
                err1_q   <= 1'b1;
                rdata1_q <= '0;
              end else begin
                ack0_q   <= 1'b1;
                err0_q   <= 1'b1;
                rdata0_q <= '0;
              end
            end else begin
              state_q <= SERVE;
              mrd_q   <= ~sel_we_d;
              mwr_q   <= sel_we_d;
            end
          end
        end
        SERVE: begin
          state_q <= DONE;
          if (id_q == PORT_DATA) begin
            ack1_q <= 1'b1;
            if (!we_q) rdata1_q <= bus.mem_d_out;
          end else begin
            ack0_q <= 1'b1;
            if (!we_q) rdata0_q <= bus.mem_d_out;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ack0     = ack0_q;
  assign bus.ack1     = ack1_q;
  assign bus.err0     = err0_q;
  assign bus.err1     = err1_q;
  assign bus.rdata0   = rdata0_q;
  assign bus.rdata1   = rdata1_q;
  assign bus.mem_adr  = adr_q;
  assign bus.mem_d_in = wdata_q;
  assign bus.mem_mrd  = mrd_q;
  assign bus.mem_mwr  = mwr_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a round-robin instance with a byte memory model
// and a fixed-priority instance for the contention comparison.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic busy_rr, busy_fp;
  int   errors = 0;
  int   checks = 0;

  logic [7:0]  mem [0:65535];
  logic [15:0] ma;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_fp ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(65536), .FIXED_PRIO(0)) u_rr (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy_rr)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(65536), .FIXED_PRIO(1)) u_fp (
    .clk(clk), .rst_n(rst_n), .bus(bus_fp), .busy(busy_fp)
  );

  always #5 clk = ~clk;

  // Little-endian byte memory, combinational read, write on the clock edge.
  assign ma            = bus.mem_adr[15:0];
  assign bus.mem_d_out = {mem[ma + 16'd3], mem[ma + 16'd2], mem[ma + 16'd1], mem[ma]};
  assign bus_fp.mem_d_out = '0;

  always @(posedge clk) begin
    if (bus.mem_mwr) begin
      mem[ma]         = bus.mem_d_in[7:0];
      mem[ma + 16'd1] = bus.mem_d_in[15:8];
      mem[ma + 16'd2] = bus.mem_d_in[23:16];
      mem[ma + 16'd3] = bus.mem_d_in[31:24];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input int unsigned a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  logic [11:0] p_rr0, p_rr1, p_fp0;
  logic [9:0]  p_hold;
  int          n_ack;

  initial begin
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.adr0 = '0; bus.adr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    bus_fp.req0 = 0; bus_fp.req1 = 0; bus_fp.we0 = 0; bus_fp.we1 = 0;
    bus_fp.adr0 = '0; bus_fp.adr1 = '0; bus_fp.wdata0 = '0; bus_fp.wdata1 = '0;
    rst_n = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[1000] = 8'h07;
    mem[2004] = 8'h78; mem[2005] = 8'h56; mem[2006] = 8'h34; mem[2007] = 8'h12;
    for (int i = 65532; i < 65536; i++) mem[i] = 8'hA5;

    repeat (2) @(negedge clk);
    // Reset state
    chk("rst_ack0", bus.ack0, 0);
    chk("rst_ack1", bus.ack1, 0);
    chk("rst_err0", bus.err0, 0);
    chk("rst_rdata0", bus.rdata0, 0);
    chk("rst_rdata1", bus.rdata1, 0);
    chk("rst_busy", busy_rr, 0);
    chk("rst_mrd", bus.mem_mrd, 0);
    chk("rst_mwr", bus.mem_mwr, 0);
    chk("rst_madr", bus.mem_adr, 0);

    // Contention from reset: both ports hold reads
    bus.adr0 = 32'd2004;  bus.adr1 = 32'd65532;
    bus.req0 = 1; bus.req1 = 1;
    bus_fp.adr0 = 32'd2004; bus_fp.adr1 = 32'd65532;
    bus_fp.req0 = 1; bus_fp.req1 = 1;
    p_rr0 = 12'h082;  // ack0 after edges 1 and 7
    p_rr1 = 12'h410;  // ack1 after edges 4 and 10
    p_fp0 = 12'h492;  // port 0 every third cycle
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk($sformatf("rr_ack0[%0d]", k), bus.ack0, p_rr0[k]);
      chk($sformatf("rr_ack1[%0d]", k), bus.ack1, p_rr1[k]);
      chk($sformatf("fp_ack0[%0d]", k), bus_fp.ack0, p_fp0[k]);
      chk($sformatf("fp_ack1[%0d]", k), bus_fp.ack1, 0);
    end
    chk("cont_rdata0", bus.rdata0, 32'h1234_5678);
    chk("cont_rdata1", bus.rdata1, 32'hA5A5_A5A5);
    chk("cont_idle", busy_rr, 0);
    bus.req0 = 0; bus.req1 = 0;
    bus_fp.req0 = 0; bus_fp.req1 = 0;
    @(negedge clk);
    chk("cont_nogrant", busy_rr, 0);

    // Single read on port 0
    bus.adr0 = 32'd1000; bus.we0 = 0; bus.req0 = 1;
    @(negedge clk);
    chk("rd_busy", busy_rr, 1);
    chk("rd_mrd_serve", bus.mem_mrd, 1);
    chk("rd_mwr_serve", bus.mem_mwr, 0);
    chk("rd_ack_early", bus.ack0, 0);
    chk("rd_madr", bus.mem_adr, 32'd1000);
    @(negedge clk);
    chk("rd_ack0", bus.ack0, 1);
    chk("rd_err0", bus.err0, 0);
    chk("rd_rdata0", bus.rdata0, 32'h7);
    chk("rd_mrd_done", bus.mem_mrd, 0);
    bus.req0 = 0;
    @(negedge clk);
    chk("rd_ack_off", bus.ack0, 0);
    chk("rd_idle", busy_rr, 0);

    // Port 1 write then read back
    bus.adr1 = 32'd2000; bus.wdata1 = 32'hDEAD_BEEF; bus.we1 = 1; bus.req1 = 1;
    @(negedge clk);
    chk("wr_mwr", bus.mem_mwr, 1);
    chk("wr_mrd", bus.mem_mrd, 0);
    chk("wr_din", bus.mem_d_in, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("wr_ack1", bus.ack1, 1);
    chk("wr_err1", bus.err1, 0);
    chk("wr_rdata1_keep", bus.rdata1, 32'hA5A5_A5A5);
    chk("wr_b2000", {24'h0, mem[2000]}, 32'hEF);
    chk("wr_b2001", {24'h0, mem[2001]}, 32'hBE);
    chk("wr_b2002", {24'h0, mem[2002]}, 32'hAD);
    chk("wr_b2003", {24'h0, mem[2003]}, 32'hDE);
    bus.req1 = 0;
    @(negedge clk);
    bus.we1 = 0; bus.req1 = 1;
    @(negedge clk);
    chk("rb_mrd", bus.mem_mrd, 1);
    @(negedge clk);
    chk("rb_ack1", bus.ack1, 1);
    chk("rb_rdata1", bus.rdata1, 32'hDEAD_BEEF);
    chk("rb_rdata0_keep", bus.rdata0, 32'h7);
    bus.req1 = 0;
    @(negedge clk);

    // Rejections: misaligned read, then out-of-range write
    bus.adr1 = 32'd1002; bus.we1 = 0; bus.req1 = 1;
    @(negedge clk);
    chk("rj1_ack1", bus.ack1, 1);
    chk("rj1_err1", bus.err1, 1);
    chk("rj1_rdata1", bus.rdata1, 0);
    chk("rj1_mrd", bus.mem_mrd, 0);
    chk("rj1_mwr", bus.mem_mwr, 0);
    bus.req1 = 0;
    @(negedge clk);
    chk("rj1_ack_off", bus.ack1, 0);
    chk("rj1_err_off", bus.err1, 0);
    chk("rj1_idle", busy_rr, 0);
    bus.adr1 = 32'd65534; bus.we1 = 1; bus.wdata1 = 32'hFFFF_FFFF; bus.req1 = 1;
    @(negedge clk);
    chk("rj2_ack1", bus.ack1, 1);
    chk("rj2_err1", bus.err1, 1);
    chk("rj2_mwr", bus.mem_mwr, 0);
    chk("rj2_mrd", bus.mem_mrd, 0);
    bus.req1 = 0;
    @(negedge clk);
    chk("rj2_mem", word_at(65532), 32'hA5A5_A5A5);

    // Reset during SERVE of a write to 2004
    bus.adr1 = 32'd2004; bus.wdata1 = 32'hCAFE_F00D; bus.we1 = 1; bus.req1 = 1;
    @(negedge clk);
    chk("rw_mwr_serve", bus.mem_mwr, 1);
    #1 rst_n = 0;
    #1;
    chk("rw_mwr_drop", bus.mem_mwr, 0);
    chk("rw_busy", busy_rr, 0);
    chk("rw_ack0", bus.ack0, 0);
    chk("rw_ack1", bus.ack1, 0);
    chk("rw_rdata1", bus.rdata1, 0);
    bus.req1 = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    chk("rw_mem2004", word_at(2004), 32'h1234_5678);
    @(negedge clk);

    // Request held across its ack: exactly two pulses, 3 cycles apart
    bus.adr0 = 32'd1000; bus.we0 = 0; bus.req0 = 1;
    p_hold = 10'b00_0001_0010;
    n_ack  = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("hold_ack0[%0d]", k), bus.ack0, p_hold[k]);
      if (bus.ack0) begin
        n_ack++;
        if (n_ack == 2) bus.req0 = 0;
      end
    end
    bus.req0 = 0;
    chk("hold_rdata0", bus.rdata0, 32'h7);
    chk("hold_idle", busy_rr, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
